mouse_param_ctrl: RTL



---
 rtl/ui_pkg.sv | 24 ++
 rtl/param_step_sat.sv | 37 +++
 rtl/mouse_param_ctrl.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/ui_pkg.sv
// Shared types and default zone layout for the mouse-driven parameter bank.
// Zone constants are packed with channel 0 in the least significant bits.
package ui_pkg;

  typedef enum logic [1:0] {
    UI_IDLE,
    UI_DELAY,
    UI_REPEAT,
    UI_WAIT_REL
  } ui_state_t;

  localparam int unsigned H_ZONE_W = 12;

  localparam logic [H_ZONE_W-1:0] H_ZONE0_LO = 12'd0;
  localparam logic [H_ZONE_W-1:0] H_ZONE0_HI = 12'd299;
  localparam logic [H_ZONE_W-1:0] H_ZONE1_LO = 12'd300;
  localparam logic [H_ZONE_W-1:0] H_ZONE1_HI = 12'd699;
  localparam logic [H_ZONE_W-1:0] H_ZONE2_LO = 12'd700;
  localparam logic [H_ZONE_W-1:0] H_ZONE2_HI = 12'd999;

  localparam logic [3*H_ZONE_W-1:0] H_ZONE_LO = {H_ZONE2_LO, H_ZONE1_LO, H_ZONE0_LO};
  localparam logic [3*H_ZONE_W-1:0] H_ZONE_HI = {H_ZONE2_HI, H_ZONE1_HI, H_ZONE0_HI};

endpackage

// File: rtl/param_step_sat.sv
// Combinational saturating step: adds or subtracts a magnitude and clamps to [min, max].
module param_step_sat #(
  parameter int unsigned VAL_W = 12
) (
  input  logic [VAL_W-1:0] i_cur,
  input  logic [VAL_W-1:0] i_step,
  input  logic             i_dir,
  input  logic [VAL_W-1:0] i_min,
  input  logic [VAL_W-1:0] i_max,
  output logic [VAL_W-1:0] o_next
);

  logic [VAL_W:0] w_sum;
  logic [VAL_W:0] w_dif;
  logic [VAL_W:0] w_raw;
  logic [VAL_W:0] w_min;
  logic [VAL_W:0] w_max;

  assign w_sum = {1'b0, i_cur} + {1'b0, i_step};
  assign w_dif = {1'b0, i_cur} - {1'b0, i_step};
  assign w_min = {1'b0, i_min};
  assign w_max = {1'b0, i_max};
  assign w_raw = i_dir ? w_sum : w_dif;

  always_comb begin
    o_next = w_raw[VAL_W-1:0];
    // Extra MSB is the borrow of a subtraction that went below zero.
    if (!i_dir && w_dif[VAL_W]) begin
      o_next = i_min;
    end else if (w_raw < w_min) begin
      o_next = i_min;
    end else if (w_raw > w_max) begin
      o_next = i_max;
    end
  end

endmodule

// File: rtl/mouse_param_ctrl.sv
// Mouse-driven multi-channel parameter bank: press-edge stepping, hold-to-repeat,
// coarse/fine steps, per-channel saturation, restore-to-default and a change strobe.
module mouse_param_ctrl
  import ui_pkg::*;
#(
  parameter int unsigned                    NUM_CH        = 3,
  parameter int unsigned                    VAL_W         = 12,
  parameter logic [NUM_CH*H_ZONE_W-1:0]     ZONE_LO       = H_ZONE_LO,
  parameter logic [NUM_CH*H_ZONE_W-1:0]     ZONE_HI       = H_ZONE_HI,
  parameter logic [NUM_CH*VAL_W-1:0]        RST_VAL       = {NUM_CH{VAL_W'(16)}},
  parameter logic [NUM_CH*VAL_W-1:0]        MIN_VAL       = {NUM_CH{VAL_W'(0)}},
  parameter logic [NUM_CH*VAL_W-1:0]        MAX_VAL       = {NUM_CH{{VAL_W{1'b1}}}},
  parameter int unsigned                    COARSE_STEP   = 10,
  parameter int unsigned                    REPEAT_DELAY  = 50_000_000,
  parameter int unsigned                    REPEAT_PERIOD = 5_000_000,
  localparam int unsigned                   CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_left_mouse,
  input  logic                    i_right_mouse,
  input  logic                    i_middle_mouse,
  input  logic [H_ZONE_W-1:0]     i_xpos,
  input  logic [H_ZONE_W-1:0]     i_ypos,
  output logic [NUM_CH*VAL_W-1:0] o_values,
  output logic [CH_W-1:0]         o_active_ch,
  output logic                    o_busy,
  output logic [NUM_CH-1:0]       o_changed
);

  localparam int unsigned CNT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX + 1) : 1;
  localparam logic [CNT_W-1:0] DLY_LAST    = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PER_LAST    = CNT_W'(REPEAT_PERIOD - 1);
  localparam logic [VAL_W-1:0] STEP_COARSE = VAL_W'(COARSE_STEP);
  localparam logic [VAL_W-1:0] STEP_FINE   = VAL_W'(1);

  ui_state_t                r_state;
  ui_state_t                w_state_nxt;
  logic [CNT_W-1:0]         r_cnt;
  logic [CNT_W-1:0]         w_cnt_nxt;
  logic [CH_W-1:0]          r_active_ch;
  logic [CH_W-1:0]          w_active_nxt;
  logic [NUM_CH*VAL_W-1:0]  r_values;
  logic [NUM_CH*VAL_W-1:0]  w_values_nxt;
  logic [NUM_CH-1:0]        r_changed;
  logic [NUM_CH-1:0]        w_changed_nxt;
  logic                     r_btn_prev;

  logic                     w_any;
  logic                     w_both;
  logic                     w_rise;
  logic                     w_hit;
  logic [CH_W-1:0]          w_hit_ch;
  logic [CH_W-1:0]          w_step_ch;
  logic                     w_do_step;
  logic [VAL_W-1:0]         w_cur;
  logic [VAL_W-1:0]         w_min;
  logic [VAL_W-1:0]         w_max;
  logic [VAL_W-1:0]         w_rst;
  logic [VAL_W-1:0]         w_mag;
  logic [VAL_W-1:0]         w_sat;
  logic [VAL_W-1:0]         w_new;
  logic                     w_unused_ypos;

  assign w_unused_ypos = ^i_ypos;

  assign w_any  = i_left_mouse | i_right_mouse;
  assign w_both = i_left_mouse & i_right_mouse;
  assign w_rise = w_any & ~r_btn_prev;

  // Scan from the top so the lowest overlapping zone wins.
  always_comb begin
    w_hit    = 1'b0;
    w_hit_ch = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if ((i_xpos >= ZONE_LO[i*H_ZONE_W +: H_ZONE_W]) &&
          (i_xpos <= ZONE_HI[i*H_ZONE_W +: H_ZONE_W])) begin
        w_hit    = 1'b1;
        w_hit_ch = CH_W'(i);
      end
    end
  end

  assign w_step_ch = (r_state == UI_IDLE) ? w_hit_ch : r_active_ch;
  assign w_cur     = r_values[int'(w_step_ch)*VAL_W +: VAL_W];
  assign w_min     = MIN_VAL[int'(w_step_ch)*VAL_W +: VAL_W];
  assign w_max     = MAX_VAL[int'(w_step_ch)*VAL_W +: VAL_W];
  assign w_rst     = RST_VAL[int'(w_step_ch)*VAL_W +: VAL_W];
  assign w_mag     = i_middle_mouse ? STEP_COARSE : STEP_FINE;
  assign w_new     = w_both ? w_rst : w_sat;

  param_step_sat #(
    .VAL_W (VAL_W)
  ) u_step_sat (
    .i_cur  (w_cur),
    .i_step (w_mag),
    .i_dir  (i_right_mouse),
    .i_min  (w_min),
    .i_max  (w_max),
    .o_next (w_sat)
  );

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_active_nxt = r_active_ch;
    w_do_step    = 1'b0;
    unique case (r_state)
      UI_IDLE: begin
        if (w_rise && w_hit) begin
          w_active_nxt = w_hit_ch;
          w_do_step    = 1'b1;
          w_cnt_nxt    = '0;
          w_state_nxt  = w_both ? UI_WAIT_REL : UI_DELAY;
        end
      end
      UI_DELAY: begin
        if (!w_any) begin
          w_cnt_nxt   = '0;
          w_state_nxt = UI_IDLE;
        end else if (r_cnt == DLY_LAST) begin
          w_do_step   = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = w_both ? UI_WAIT_REL : UI_REPEAT;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      UI_REPEAT: begin
        if (!w_any) begin
          w_cnt_nxt   = '0;
          w_state_nxt = UI_IDLE;
        end else if (r_cnt == PER_LAST) begin
          w_do_step   = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = w_both ? UI_WAIT_REL : UI_REPEAT;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      UI_WAIT_REL: begin
        if (!w_any) begin
          w_state_nxt = UI_IDLE;
        end
      end
      default: begin
        w_cnt_nxt   = '0;
        w_state_nxt = UI_IDLE;
      end
    endcase
  end

  always_comb begin
    w_values_nxt  = r_values;
    w_changed_nxt = '0;
    if (w_do_step && (w_new != w_cur)) begin
      w_values_nxt[int'(w_step_ch)*VAL_W +: VAL_W] = w_new;
      w_changed_nxt[w_step_ch]                     = 1'b1;
    end
  end

  // Button history resets high so buttons still held across a reset are not a new press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= UI_IDLE;
      r_cnt       <= '0;
      r_active_ch <= '0;
      r_values    <= RST_VAL;
      r_changed   <= '0;
      r_btn_prev  <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_active_ch <= w_active_nxt;
      r_values    <= w_values_nxt;
      r_changed   <= w_changed_nxt;
      r_btn_prev  <= w_any;
    end
  end

  assign o_values    = r_values;
  assign o_active_ch = r_active_ch;
  assign o_busy      = (r_state == UI_DELAY) || (r_state == UI_REPEAT);
  assign o_changed   = r_changed;

endmodule
